uart_tx_byte_fifo: RTL and testbench
====================================

Name: uart_tx_byte_fifo

Overview:
- Byte FIFO plus transmit sequencer between the UART receiver's byte output and the UART transmitter's byte input.
- Absorbs back-to-back received bytes and feeds them to the transmitter one at a time, waiting for each transmission to finish before launching the next.
- Replaces the direct RX-to-TX loopback wiring so that bursts faster than TX drain, or TX stalls, do not lose data until the FIFO fills.
- Also exports occupancy and a sticky overflow flag for display/debug.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, 2..256.
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
- i_Clk  input  1  system clock (25 MHz board clock); all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_RX_DV  input  1  one-cycle strobe from the UART receiver; a received byte is valid.
- i_RX_Byte  input  8  received byte, sampled when i_RX_DV=1.
- i_TX_Active  input  1  UART transmitter busy flag.
- i_TX_Done  input  1  one-cycle strobe from the UART transmitter; stop bit finished.
- i_Clear_Overflow  input  1  clears o_Overflow.
- o_TX_DV  output  1  one-cycle launch strobe to the UART transmitter.
- o_TX_Byte  output  8  byte to transmit; held stable from o_TX_DV until the next launch.
- o_Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- o_Empty  output  1  o_Count==0.
- o_Full  output  1  o_Count==DEPTH.
- o_Overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- **Reset values** (synchronous): write/read pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Overflow 0, o_TX_DV 0, o_TX_Byte 8'h00, FSM in IDLE.
- **Storage:** register/RAM array of DEPTH x 8. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. o_Count is kept as an explicit counter.

Push:
- On i_RX_DV=1 and not full, write i_RX_Byte at wr_ptr and increment wr_ptr.
- On i_RX_DV=1 while full and no pop in the same cycle, drop the byte, leave pointers and count unchanged, and set o_Overflow=1.
- If a pop occurs in the same cycle as a push while full, the push is accepted; count stays at DEPTH.

Pop:
- Happens only on the FSM IDLE->WAIT_ACTIVE transition.
- Registers mem[rd_ptr] into o_TX_Byte and increments rd_ptr.
- Simultaneous push and pop leaves the count unchanged.
- Pop from an empty FIFO cannot occur; the FSM guards it.

Overflow flag:
- i_Clear_Overflow=1 clears o_Overflow.
- A drop in the same cycle as a clear wins (o_Overflow=1).

FSM states:
- **IDLE:** if count!=0 and i_TX_Active=0, pop, drive o_TX_DV=1 for exactly one cycle, and go to WAIT_ACTIVE. Otherwise stay.
- **WAIT_ACTIVE:** o_TX_DV=0. On i_TX_Active=1 go to WAIT_DONE. If i_TX_Done=1 arrives first (very short frame), go to IDLE.
- **WAIT_DONE:** on i_TX_Done=1 go to IDLE.

Latency and throughput:
- i_RX_DV at cycle N into an empty FIFO with TX idle gives count=1 at N+1 and o_TX_DV=1 with valid o_TX_Byte at N+2. There is no fall-through bypass.
- Next launch comes no earlier than 1 cycle after i_TX_Done (IDLE re-evaluates in the following cycle), and only if i_TX_Active=0 then.

Other rules:
- **Reset mid-transmission:** FIFO contents are discarded. The external transmitter may still be active, so the FSM leaves IDLE only once i_TX_Active=0; no launch ever overlaps an active frame.
- **Ordering:** strict first-in first-out; no byte duplicated or reordered.
- **o_TX_DV** is never asserted in two consecutive cycles.

Test Plan:
1. Reset, then single byte 8'hA5 on i_RX_DV with TX model idle -> o_TX_DV one-cycle pulse 2 cycles later, o_TX_Byte=8'hA5, o_Count 1 then 0, o_Empty returns 1.
2. Burst of 5 bytes 8'h01..8'h05 on consecutive cycles, TX model taking 2170 cycles per frame -> o_Count peaks at 4 or 5; TX receives 01,02,03,04,05 in order; exactly one launch per i_TX_Done.
3. Hold TX model active and push 17 bytes with DEPTH=16 -> o_Full=1 after 16th, 17th dropped, o_Overflow=1. Release TX -> bytes 1..16 emerge. Pulse i_Clear_Overflow -> o_Overflow=0.
4. When full, push in the same cycle the FSM pops -> push accepted, o_Count stays 16, no overflow; byte order correct across pointer wrap (rd/wr pass index 15->0).
5. Assert i_Rst for 1 cycle while 3 bytes queued and TX active -> o_Count=0, o_TX_DV=0. A byte pushed afterwards is not launched until i_TX_Active drops.
6. Simultaneous i_Clear_Overflow and a dropped push when full -> o_Overflow remains 1.

Source files
------------

// File: rtl/uart_tx_byte_fifo.sv
// Byte FIFO between the UART receiver and transmitter, with a launch sequencer
// that starts one transmission at a time and exposes occupancy and overflow status.
module uart_tx_byte_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  input  logic                  i_TX_Active,
  input  logic                  i_TX_Done,
  input  logic                  i_Clear_Overflow,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  output logic [ADDR_WIDTH:0]   o_Count,
  output logic                  o_Empty,
  output logic                  o_Full,
  output logic                  o_Overflow,
  output logic [1:0]            o_Dbg_State
);

  // Handshake: i_RX_DV and i_TX_Done are single-cycle strobes with no back-pressure;
  // o_TX_DV is a single-cycle launch issued only while i_TX_Active is low.
  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACTIVE = 2'd1,
    S_WAIT_DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_dv_q, tx_dv_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  state_t                state_q, state_d;

  logic full, empty, push, pop, drop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Also the recovery path after reset: never launch over a busy transmitter.
        if (!empty && !i_TX_Active) begin
          pop     = 1'b1;
          state_d = S_WAIT_ACTIVE;
        end
      end
      S_WAIT_ACTIVE: begin
        if (i_TX_Done) begin
          state_d = S_IDLE;
        end else if (i_TX_Active) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_TX_Done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    push       = i_RX_DV && (!full || pop);
    drop       = i_RX_DV && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + (ADDR_WIDTH+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_WIDTH+1)'(1);
    end
    tx_dv_d    = pop;
    tx_byte_d  = pop ? mem_q[rd_ptr_q] : tx_byte_q;
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (i_Clear_Overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_RX_Byte;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      state_q    <= state_d;
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Count     = count_q;
  assign o_Empty     = empty;
  assign o_Full      = full;
  assign o_Overflow  = overflow_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_tx_byte_fifo.sv
// Directed bench for uart_tx_byte_fifo: a behavioural UART transmitter model
// records every launched byte, and each scenario task checks its own results.
module tb_uart_tx_byte_fifo;

  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;

  logic                i_Clk = 1'b0;
  logic                i_Rst = 1'b1;
  logic                i_RX_DV = 1'b0;
  logic [7:0]          i_RX_Byte = 8'h00;
  logic                i_TX_Active = 1'b0;
  logic                i_TX_Done = 1'b0;
  logic                i_Clear_Overflow = 1'b0;
  logic                o_TX_DV;
  logic [7:0]          o_TX_Byte;
  logic [ADDR_WIDTH:0] o_Count;
  logic                o_Empty;
  logic                o_Full;
  logic                o_Overflow;
  logic [1:0]          o_Dbg_State;

  int total = 0;
  int bad   = 0;

  // Transmitter model state
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  frame_len = 8;
  int  remaining = 0;
  bit  tx_hold = 1'b0;
  bit  dv_prev = 1'b0;
  int  launch_cnt = 0;
  int  done_cnt = 0;
  int  dv_consec_err = 0;
  int  overlap_err = 0;

  uart_tx_byte_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_Clk            (i_Clk),
    .i_Rst            (i_Rst),
    .i_RX_DV          (i_RX_DV),
    .i_RX_Byte        (i_RX_Byte),
    .i_TX_Active      (i_TX_Active),
    .i_TX_Done        (i_TX_Done),
    .i_Clear_Overflow (i_Clear_Overflow),
    .o_TX_DV          (o_TX_DV),
    .o_TX_Byte        (o_TX_Byte),
    .o_Count          (o_Count),
    .o_Empty          (o_Empty),
    .o_Full           (o_Full),
    .o_Overflow       (o_Overflow),
    .o_Dbg_State      (o_Dbg_State)
  );

  // Clock / reset
  always #5 i_Clk = ~i_Clk;

  // Transmitter model: goes busy on a launch, stays busy frame_len cycles, then strobes done.
  always @(posedge i_Clk) begin
    #1;
    i_TX_Done = 1'b0;
    if (o_TX_DV) begin
      if (dv_prev) dv_consec_err++;
      if (i_TX_Active) overlap_err++;
      got_q.push_back(o_TX_Byte);
      launch_cnt++;
      i_TX_Active = 1'b1;
      remaining = frame_len;
    end else if (tx_hold) begin
      i_TX_Active = 1'b1;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        i_TX_Active = 1'b0;
        i_TX_Done = 1'b1;
        done_cnt++;
      end
    end else begin
      i_TX_Active = 1'b0;
    end
    dv_prev = o_TX_DV;
  end

  // Driver tasks
  task automatic push_byte(input logic [7:0] b, input logic clr);
    i_RX_DV = 1'b1;
    i_RX_Byte = b;
    i_Clear_Overflow = clr;
    @(negedge i_Clk);
    i_RX_DV = 1'b0;
    i_Clear_Overflow = 1'b0;
  endtask

  task automatic wait_launches(input int n, input int budget, output bit ok);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      @(negedge i_Clk);
      c++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Clk);
    total++; if (o_Count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_Count); end
    total++; if (o_Empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", o_Empty); end
    total++; if (o_Full !== 1'b0 || o_Overflow !== 1'b0 || o_TX_DV !== 1'b0) begin
      bad++; $display("FAIL reset_flags full=%b ovf=%b dv=%b exp=000", o_Full, o_Overflow, o_TX_DV); end
    total++; if (o_TX_Byte !== 8'h00) begin bad++; $display("FAIL reset_byte got=%h exp=00", o_TX_Byte); end
    total++; if (o_Dbg_State !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", o_Dbg_State); end
    i_Rst = 1'b0;
    @(negedge i_Clk);
  endtask

  task automatic test_single();
    int d0;
    bit ok;
    frame_len = 8;
    got_q.delete();
    d0 = done_cnt;
    push_byte(8'hA5, 1'b0);
    total++; if (o_Count !== 5'd1 || o_TX_DV !== 1'b0) begin
      bad++; $display("FAIL single_n1 count=%0d dv=%b exp count=1 dv=0", o_Count, o_TX_DV); end
    @(negedge i_Clk);
    total++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'hA5) begin
      bad++; $display("FAIL single_launch dv=%b byte=%h exp dv=1 byte=a5", o_TX_DV, o_TX_Byte); end
    total++; if (o_Count !== 5'd0 || o_Empty !== 1'b1) begin
      bad++; $display("FAIL single_drained count=%0d empty=%b exp 0/1", o_Count, o_Empty); end
    @(negedge i_Clk);
    total++; if (o_TX_DV !== 1'b0) begin bad++; $display("FAIL single_pulse_width dv=%b exp=0", o_TX_DV); end
    wait_launches(1, 50, ok);
    repeat (frame_len + 3) @(negedge i_Clk);
    total++; if (done_cnt - d0 !== 1 || got_q.size() !== 1) begin
      bad++; $display("FAIL single_frame dones=%0d launches=%0d exp 1/1", done_cnt - d0, got_q.size()); end
    total++; if (o_TX_Byte !== 8'hA5) begin bad++; $display("FAIL single_hold_byte got=%h exp=a5", o_TX_Byte); end
  endtask

  task automatic test_burst();
    int peak = 0;
    int d0;
    int l0;
    int c = 0;
    int extra = 0;
    frame_len = 2170;
    got_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    l0 = launch_cnt;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      i_RX_DV = 1'b1;
      i_RX_Byte = 8'(i);
      @(negedge i_Clk);
      if (int'(o_Count) > peak) peak = int'(o_Count);
    end
    i_RX_DV = 1'b0;
    repeat (3) begin
      @(negedge i_Clk);
      if (int'(o_Count) > peak) peak = int'(o_Count);
    end
    total++; if (!(peak == 4 || peak == 5)) begin bad++; $display("FAIL burst_peak got=%0d exp=4..5", peak); end
    while ((done_cnt - d0 < 5) && c < 6 * 2200) begin
      @(negedge i_Clk);
      if ((launch_cnt - l0) > (done_cnt - d0) + 1) extra++;
      c++;
    end
    total++; if (done_cnt - d0 !== 5 || launch_cnt - l0 !== 5) begin
      bad++; $display("FAIL burst_drain dones=%0d launches=%0d exp 5/5", done_cnt - d0, launch_cnt - l0); end
    total++; if (extra !== 0) begin bad++; $display("FAIL burst_one_per_done early=%0d exp=0", extra); end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
      total++; if (g !== e) begin bad++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_overflow();
    frame_len = 6;
    got_q.delete();
    tx_hold = 1'b1;
    repeat (2) @(negedge i_Clk);
    for (int i = 0; i < DEPTH; i++) begin
      i_RX_DV = 1'b1;
      i_RX_Byte = 8'h30 + 8'(i);
      @(negedge i_Clk);
    end
    i_RX_DV = 1'b0;
    total++; if (o_Count !== 5'd16 || o_Full !== 1'b1 || o_Overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_fill count=%0d full=%b ovf=%b exp 16/1/0", o_Count, o_Full, o_Overflow); end
    push_byte(8'hEE, 1'b0);
    total++; if (o_Count !== 5'd16 || o_Overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_drop count=%0d ovf=%b exp 16/1", o_Count, o_Overflow); end
    i_Clear_Overflow = 1'b1;
    @(negedge i_Clk);
    i_Clear_Overflow = 1'b0;
    total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", o_Overflow); end
    push_byte(8'hEF, 1'b1);
    total++; if (o_Overflow !== 1'b1 || o_Count !== 5'd16) begin
      bad++; $display("FAIL ovf_clear_vs_drop ovf=%b count=%0d exp 1/16", o_Overflow, o_Count); end
    i_Clear_Overflow = 1'b1;
    @(negedge i_Clk);
    i_Clear_Overflow = 1'b0;
    total++; if (o_Overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0", o_Overflow); end
  endtask

  task automatic test_full_push_pop();
    bit ok;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'h30 + 8'(i));
    exp_q.push_back(8'h11);
    tx_hold = 1'b0;
    @(negedge i_Clk);
    push_byte(8'h11, 1'b0);
    total++; if (o_TX_DV !== 1'b1 || o_TX_Byte !== 8'h30) begin
      bad++; $display("FAIL pushpop_launch dv=%b byte=%h exp 1/30", o_TX_DV, o_TX_Byte); end
    total++; if (o_Count !== 5'd16 || o_Overflow !== 1'b0) begin
      bad++; $display("FAIL pushpop_count count=%0d ovf=%b exp 16/0", o_Count, o_Overflow); end
    wait_launches(DEPTH + 1, (DEPTH + 1) * (frame_len + 6) + 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL pushpop_drain launches=%0d exp=%0d", got_q.size(), DEPTH + 1); end
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] e;
      logic [7:0] g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hXX;
      total++; if (g !== e) begin bad++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, g, e); end
    end
    repeat (frame_len + 4) @(negedge i_Clk);
    total++; if (o_Empty !== 1'b1 || o_Overflow !== 1'b0) begin
      bad++; $display("FAIL pushpop_end empty=%b ovf=%b exp 1/0", o_Empty, o_Overflow); end
  endtask

  task automatic test_reset_mid();
    int l0;
    bit ok;
    frame_len = 6;
    got_q.delete();
    tx_hold = 1'b1;
    repeat (2) @(negedge i_Clk);
    for (int i = 0; i < 3; i++) push_byte(8'h50 + 8'(i), 1'b0);
    total++; if (o_Count !== 5'd3) begin bad++; $display("FAIL rstmid_queued got=%0d exp=3", o_Count); end
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    total++; if (o_Count !== 5'd0 || o_TX_DV !== 1'b0 || o_Empty !== 1'b1) begin
      bad++; $display("FAIL rstmid_cleared count=%0d dv=%b empty=%b exp 0/0/1", o_Count, o_TX_DV, o_Empty); end
    l0 = launch_cnt;
    push_byte(8'h77, 1'b0);
    repeat (10) @(negedge i_Clk);
    total++; if (launch_cnt !== l0 || o_Count !== 5'd1) begin
      bad++; $display("FAIL rstmid_blocked launches=%0d count=%0d exp 0/1", launch_cnt - l0, o_Count); end
    tx_hold = 1'b0;
    wait_launches(1, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstmid_launch_timeout launches=%0d exp=1", got_q.size()); end
    total++; if (ok && got_q[0] !== 8'h77) begin bad++; $display("FAIL rstmid_byte got=%h exp=77", got_q[0]); end
    repeat (frame_len + 4) @(negedge i_Clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    total++; if (dv_consec_err !== 0) begin bad++; $display("FAIL dv_consecutive got=%0d exp=0", dv_consec_err); end
    total++; if (overlap_err !== 0) begin bad++; $display("FAIL launch_overlap got=%0d exp=0", overlap_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
